isu_rob_arb: RTL and testbench

- Issue-stage scheduler that shares ROB-ID allocation between the three request channels.
- Each cycle, round-robin arbitrates among requesting channels that still hold ROB credit, grants at most one, and returns that channel's next in-order ROB ID.
- Tracks per-channel outstanding entries via in-order retire, and blocks a channel when its ROB window is full.
- Sits between the channel request queues and the ROB/dispatch logic.

---
 rtl/isu_rob_arb_if.sv | 41 ++++
 rtl/isu_rob_arb.sv | 123 ++++++++++++
 tb/tb_isu_rob_arb.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/isu_rob_arb_if.sv
// rtl/isu_rob_arb_if.sv - request/grant, ROB-ID and retire bundle for isu_rob_arb
//
// Purpose: groups the channel request/grant handshake, the allocated ROB-ID
// result, the retire feed and the per-channel status flags.
// Signals:
//   u_req                 per-channel issue request (level, held until granted)
//   u_gnt                 one-hot grant or zero, same cycle
//   d_valid               an ID is allocated this cycle
//   d_channel_1hot        granted channel (equals u_gnt)
//   d_rob_id              ID allocated to the granted channel, 0 when idle
//   r_retire_valid        one entry retires this cycle
//   r_retire_channel_1hot channel of the retiring entry
//   d_ch_full/d_ch_empty  registered per-channel full/empty flags
//   d_err                 sticky illegal-retire flag
// Modports: master drives requests and retires; slave is the arbiter.

interface isu_rob_arb_if #(
  parameter int CH_NUM    = 3,
  parameter int ROB_WIDTH = 4
);
  logic [CH_NUM-1:0]    u_req;
  logic [CH_NUM-1:0]    u_gnt;
  logic                 d_valid;
  logic [CH_NUM-1:0]    d_channel_1hot;
  logic [ROB_WIDTH-1:0] d_rob_id;
  logic                 r_retire_valid;
  logic [CH_NUM-1:0]    r_retire_channel_1hot;
  logic [CH_NUM-1:0]    d_ch_full;
  logic [CH_NUM-1:0]    d_ch_empty;
  logic                 d_err;

  modport master (
    output u_req, r_retire_valid, r_retire_channel_1hot,
    input  u_gnt, d_valid, d_channel_1hot, d_rob_id, d_ch_full, d_ch_empty, d_err
  );

  modport slave (
    input  u_req, r_retire_valid, r_retire_channel_1hot,
    output u_gnt, d_valid, d_channel_1hot, d_rob_id, d_ch_full, d_ch_empty, d_err
  );
endinterface

// File: rtl/isu_rob_arb.sv
// rtl/isu_rob_arb.sv - round-robin ROB-ID allocator shared by issue channels
//
// Purpose: each cycle grants at most one requesting channel that still has
// ROB credit, returns that channel's next in-order ROB ID in the same cycle,
// and tracks per-channel occupancy through in-order retires.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    isu_rob_arb_if slave modport (requests, grant/ID, retire, status)

module isu_rob_arb #(
  parameter int CH_NUM    = 3,
  parameter int ROB_WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  isu_rob_arb_if.slave  bus
);

  localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int CNT_W = ROB_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ROB_WIDTH{1'b0}}};

  logic [ROB_WIDTH-1:0] alloc_ptr_q  [CH_NUM];
  logic [ROB_WIDTH-1:0] alloc_ptr_d  [CH_NUM];
  logic [ROB_WIDTH-1:0] retire_ptr_q [CH_NUM];
  logic [ROB_WIDTH-1:0] retire_ptr_d [CH_NUM];
  logic [CNT_W-1:0]     cnt_q        [CH_NUM];
  logic [CNT_W-1:0]     cnt_d        [CH_NUM];
  logic [CH_NUM-1:0]    rr_ptr_q, rr_ptr_d;
  logic                 err_q, err_d;

  logic [CH_NUM-1:0]    full_vec, empty_vec, elig;
  logic [CH_NUM-1:0]    gnt;
  logic [IDX_W-1:0]     rr_idx, gnt_idx;
  logic                 gnt_found;
  int                   scan_idx;

  logic                 ret_onehot, ret_ok, ret_err;
  logic [CH_NUM-1:0]    ret_vec;

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      full_vec[i]  = (cnt_q[i] == DEPTH);
      empty_vec[i] = (cnt_q[i] == '0);
    end
  end

  // Holding eligibility low during reset keeps every grant output at zero.
  assign elig = bus.u_req & ~full_vec & {CH_NUM{rst_n}};

  always_comb begin
    rr_idx = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (rr_ptr_q[i]) rr_idx = IDX_W'(i);
    end
  end

  // Scan from rr_ptr upward with wrap; first eligible channel wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    scan_idx  = 0;
    for (int k = 0; k < CH_NUM; k++) begin
      scan_idx = int'(rr_idx) + k;
      if (scan_idx >= CH_NUM) scan_idx = scan_idx - CH_NUM;
      if (!gnt_found && elig[scan_idx]) begin
        gnt[scan_idx] = 1'b1;
        gnt_idx       = IDX_W'(scan_idx);
        gnt_found     = 1'b1;
      end
    end
  end

  // A retire only takes effect when it names exactly one non-empty channel;
  // anything else is dropped and flagged.
  assign ret_onehot = $onehot(bus.r_retire_channel_1hot);
  assign ret_ok     = bus.r_retire_valid && ret_onehot &&
                      |(bus.r_retire_channel_1hot & ~empty_vec);
  assign ret_err    = bus.r_retire_valid && !ret_ok;
  assign ret_vec    = ret_ok ? bus.r_retire_channel_1hot : '0;

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      alloc_ptr_d[i]  = alloc_ptr_q[i] + ROB_WIDTH'(gnt[i]);
      retire_ptr_d[i] = retire_ptr_q[i] + ROB_WIDTH'(ret_vec[i]);
      cnt_d[i]        = cnt_q[i] + CNT_W'(gnt[i]) - CNT_W'(ret_vec[i]);
    end
    // Rotating the grant left gives one-hot of (g+1) mod CH_NUM.
    rr_ptr_d = gnt_found ? {gnt[CH_NUM-2:0], gnt[CH_NUM-1]} : rr_ptr_q;
    err_d    = err_q | ret_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        alloc_ptr_q[i]  <= '0;
        retire_ptr_q[i] <= '0;
        cnt_q[i]        <= '0;
      end
      rr_ptr_q <= CH_NUM'(1);
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        alloc_ptr_q[i]  <= alloc_ptr_d[i];
        retire_ptr_q[i] <= retire_ptr_d[i];
        cnt_q[i]        <= cnt_d[i];
      end
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign bus.u_gnt          = gnt;
  assign bus.d_valid        = gnt_found;
  assign bus.d_channel_1hot = gnt;
  assign bus.d_rob_id       = gnt_found ? alloc_ptr_q[gnt_idx] : '0;
  assign bus.d_ch_full      = full_vec;
  assign bus.d_ch_empty     = empty_vec;
  assign bus.d_err          = err_q;

endmodule

// File: tb/tb_isu_rob_arb.sv
// tb/tb_isu_rob_arb.sv - scoreboard bench for isu_rob_arb
module tb_isu_rob_arb;

  localparam int CH    = 3;
  localparam int RW    = 2;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  isu_rob_arb_if #(.CH_NUM(CH), .ROB_WIDTH(RW)) ifc ();

  isu_rob_arb #(.CH_NUM(CH), .ROB_WIDTH(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  typedef struct packed {
    logic [CH-1:0] gnt;
    logic          valid;
    logic [RW-1:0] id;
    logic [CH-1:0] full;
    logic [CH-1:0] empty;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  int   m_alloc [CH];
  int   m_cnt   [CH];
  int   m_rr;
  bit   m_err;

  logic [CH-1:0] last_gnt;
  logic [RW-1:0] last_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_alloc[i] = 0;
      m_cnt[i]   = 0;
    end
    m_rr  = 0;
    m_err = 1'b0;
  endtask

  // One clock of stimulus: predict, push, compare at negedge+1, then advance model.
  task automatic step(input logic [CH-1:0] req, input logic rv, input logic [CH-1:0] rch);
    exp_t e, o;
    int   g, r, ones;
    @(negedge clk);
    ifc.u_req                 = req;
    ifc.r_retire_valid        = rv;
    ifc.r_retire_channel_1hot = rch;
    g = -1;
    for (int k = 0; k < CH; k++) begin
      int c;
      c = (m_rr + k) % CH;
      if (g < 0 && req[c] && m_cnt[c] < DEPTH) g = c;
    end
    e.gnt   = (g >= 0) ? CH'(1 << g) : '0;
    e.valid = (g >= 0);
    e.id    = (g >= 0) ? RW'(m_alloc[g]) : '0;
    for (int i = 0; i < CH; i++) begin
      e.full[i]  = (m_cnt[i] == DEPTH);
      e.empty[i] = (m_cnt[i] == 0);
    end
    e.err = m_err;
    sb.push_back(e);
    #1;
    o = sb.pop_front();
    check("u_gnt",          32'(ifc.u_gnt),          32'(o.gnt));
    check("d_valid",        32'(ifc.d_valid),        32'(o.valid));
    check("d_channel_1hot", 32'(ifc.d_channel_1hot), 32'(o.gnt));
    check("d_rob_id",       32'(ifc.d_rob_id),       32'(o.id));
    check("d_ch_full",      32'(ifc.d_ch_full),      32'(o.full));
    check("d_ch_empty",     32'(ifc.d_ch_empty),     32'(o.empty));
    check("d_err",          32'(ifc.d_err),          32'(o.err));
    last_gnt = ifc.u_gnt;
    last_id  = ifc.d_rob_id;
    @(posedge clk);
    // Retire legality is judged on the counts before this edge's grant.
    if (rv) begin
      ones = 0;
      r    = 0;
      for (int i = 0; i < CH; i++) if (rch[i]) begin ones++; r = i; end
      if (ones != 1 || m_cnt[r] == 0) m_err = 1'b1;
      else m_cnt[r]--;
    end
    if (g >= 0) begin
      m_alloc[g] = (m_alloc[g] + 1) % DEPTH;
      m_cnt[g]++;
      m_rr = (g + 1) % CH;
    end
  endtask

  task automatic do_reset();
    ifc.u_req                 = '1;
    ifc.r_retire_valid        = 1'b0;
    ifc.r_retire_channel_1hot = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_gnt",   32'(ifc.u_gnt),      32'h0);
    check("rst_valid", 32'(ifc.d_valid),    32'h0);
    check("rst_id",    32'(ifc.d_rob_id),   32'h0);
    check("rst_empty", 32'(ifc.d_ch_empty), 32'h7);
    check("rst_full",  32'(ifc.d_ch_full),  32'h0);
    check("rst_err",   32'(ifc.d_err),      32'h0);
    @(negedge clk);
    ifc.u_req = '0;
    rst_n     = 1'b1;
    model_reset();
  endtask

  logic [CH-1:0] s1_gnt [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [RW-1:0] s1_id  [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};

  initial begin
    ifc.u_req                 = '0;
    ifc.r_retire_valid        = 1'b0;
    ifc.r_retire_channel_1hot = '0;
    model_reset();

    // All three channels requesting: rotating grants, IDs advance per channel.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(3'b111, 1'b0, 3'b000);
      check("s1_gnt_seq", 32'(last_gnt), 32'(s1_gnt[i]));
      check("s1_id_seq",  32'(last_id),  32'(s1_id[i]));
    end

    // ch0 alone fills its window, is held off, then resumes with wrapped ID.
    do_reset();
    for (int i = 0; i < 4; i++) step(3'b001, 1'b0, 3'b000);
    step(3'b001, 1'b0, 3'b000);
    check("full_no_gnt", 32'(last_gnt), 32'h0);
    step(3'b001, 1'b1, 3'b001);
    check("retire_full_no_gnt", 32'(last_gnt), 32'h0);
    step(3'b001, 1'b0, 3'b000);
    check("wrap_gnt", 32'(last_gnt), 32'h1);
    check("wrap_id",  32'(last_id),  32'h0);
    step(3'b000, 1'b0, 3'b000);

    // Simultaneous grant and retire on ch1 keeps its count.
    do_reset();
    step(3'b010, 1'b0, 3'b000);
    step(3'b010, 1'b0, 3'b000);
    step(3'b010, 1'b1, 3'b010);
    step(3'b000, 1'b1, 3'b010);
    step(3'b000, 1'b1, 3'b010);
    step(3'b010, 1'b0, 3'b000);
    check("ch1_id_after_retire", 32'(last_id), 32'h3);

    // Illegal retires: empty channel, then non-one-hot channel vector.
    do_reset();
    step(3'b000, 1'b1, 3'b100);
    step(3'b000, 1'b0, 3'b000);
    step(3'b100, 1'b0, 3'b000);
    do_reset();
    step(3'b011, 1'b0, 3'b000);
    step(3'b011, 1'b0, 3'b000);
    step(3'b000, 1'b1, 3'b011);
    step(3'b011, 1'b0, 3'b000);
    step(3'b011, 1'b0, 3'b000);

    // ch0 full, ch1 granted every cycle until full; rr only moves on grants.
    do_reset();
    for (int i = 0; i < 4; i++) step(3'b001, 1'b0, 3'b000);
    for (int i = 0; i < 5; i++) step(3'b011, 1'b0, 3'b000);
    step(3'b111, 1'b0, 3'b000);
    step(3'b000, 1'b1, 3'b101);
    step(3'b011, 1'b0, 3'b000);

    // Asynchronous reset mid-cycle takes effect immediately.
    @(posedge clk);
    #3;
    ifc.u_req = 3'b111;
    rst_n     = 1'b0;
    #1;
    check("async_gnt",   32'(ifc.u_gnt),      32'h0);
    check("async_valid", 32'(ifc.d_valid),    32'h0);
    check("async_empty", 32'(ifc.d_ch_empty), 32'h7);
    check("async_full",  32'(ifc.d_ch_full),  32'h0);
    check("async_err",   32'(ifc.d_err),      32'h0);
    @(negedge clk);
    ifc.u_req = '0;
    rst_n     = 1'b1;
    model_reset();
    step(3'b100, 1'b0, 3'b000);
    step(3'b111, 1'b0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
